product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 4x4 Wallace-tree multiplier.
- Consumes one 8-bit unsigned product per handshake and accumulates a run of products into a dot-product sum.
- Presents the finished sum with a term count and an overflow flag on a valid/ready output port.
- Sits between the multiplier and the result-collection logic of the arithmetic datapath.

Parameters:
- ACC_W, 10, accumulator/sum width in bits; must be at least 8.
- MAX_TERMS, 16, maximum products per run; a run closes automatically when this count is reached.
- CNT_W, 5, width of the term counter; must satisfy 2**CNT_W > MAX_TERMS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort of the current run; lower priority than rst.
- in_valid  input  1  in_product/in_last are valid.
- in_ready  output  1  block can accept a product this cycle.
- in_product  input  8  unsigned product from the multiplier.
- in_last  input  1  this product is the final term of the run.
- out_valid  output  1  out_sum/out_count/out_overflow are valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  accumulated sum, modulo 2**ACC_W.
- out_count  output  CNT_W  number of products in the run.
- out_overflow  output  1  sticky; set if any addition in the run carried out of ACC_W.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE; acc=0; count=0; ovf=0; out_valid=0; in_ready=1.
- Acceptance: a product is taken when in_valid && in_ready at a clock edge.
- in_ready is purely a function of state: 1 in IDLE and ACCUM, 0 in HOLD. There is no combinational path from out_ready to in_ready.
- Accumulation: {carry, acc} <= acc + zero-extended in_product, computed at ACC_W+1 bits.
  - acc takes the low ACC_W bits, so the sum wraps.
  - ovf <= ovf | carry.
  - count <= count + 1.
- States:
  - IDLE: acc=0, count=0. An accepted product with in_last=1 goes to HOLD. An accepted product with in_last=0 goes to ACCUM.
  - ACCUM: an accepted product goes to HOLD if in_last=1 or the new count equals MAX_TERMS. Otherwise the state stays ACCUM.
  - HOLD: out_valid=1. out_sum, out_count and out_overflow hold the registered final values and stay stable while out_ready=0. On out_ready=1: clear acc, count and ovf, go to IDLE, and drop out_valid on the next cycle.
- Latency:
  - The result is visible (out_valid=1) on the cycle after the closing product is accepted.
  - There is a minimum of one bubble cycle between runs.
  - Throughput within a run is one product per cycle.
- Result outputs are 0 outside HOLD. out_valid is registered.
- clear: in IDLE or ACCUM, acc, count and ovf are zeroed and the state goes to IDLE. Any product presented in the same cycle is dropped, and in_ready is still 1 in that cycle. In HOLD, clear is ignored so a pending result is never lost.
- rst in any state, including mid-run or HOLD, discards everything and returns to the reset values above.
- in_last together with count reaching MAX_TERMS in the same cycle is a single close event, not a double one.
- in_product=0 is counted as a term like any other.

Decomposition:
- Shared include header (arith_defs.vh):
  - state encodings ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_HOLD=2'd2;
  - default widths for ACC_W, MAX_TERMS and CNT_W, shared with the multiplier stage.
- No sub-module is required.
- The ACC_W+1-bit adder is a single expression. A separate acc_adder module would only be justified if a fast adder is later substituted, and it must keep the same carry-out contract.

Test Plan:
- Single-term run: reset, then in_product=225 with in_last=1 -> next cycle out_valid=1, out_sum=225, out_count=1, out_overflow=0; out_ready=1 -> IDLE, in_ready=1.
- Overflow wrap: 5 x 225 (last on 5th) -> out_sum=101 (1125 mod 1024), out_count=5, out_overflow=1.
- Auto-close at MAX_TERMS: 16 x 1 with in_last never asserted -> HOLD after 16th accept, out_sum=16, out_count=16, out_overflow=0.
- Backpressure: in HOLD, hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, outputs stable, no product consumed; release -> next run starts from 0.
- clear mid-run: accept 30, 40, then clear=1 with in_product=50 valid -> state IDLE, acc=0; next run of a single 7 with last -> out_sum=7, out_count=1.
- Reset in HOLD: rst=1 while out_valid=1 -> next cycle out_valid=0, in_ready=1, all outputs 0.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: FSM encoding and default widths
// that match the multiplier stage feeding this block.
package product_accumulator_pkg;

    localparam int ACC_W_DEF     = 10;
    localparam int MAX_TERMS_DEF = 16;
    localparam int CNT_W_DEF     = 5;
    localparam int PROD_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/product_accumulator.sv
// Accumulates a run of 8-bit unsigned products into a wrapping sum with a term
// count and sticky overflow, and presents the result on a valid/ready port.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PROD_W-1:0]  in_product,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_overflow
);

    if (ACC_W < PROD_W) begin : g_acc_w_check
        $error("ACC_W must be at least the product width");
    end
    if ((2 ** CNT_W) <= MAX_TERMS) begin : g_cnt_w_check
        $error("CNT_W too narrow for MAX_TERMS");
    end

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on state; out_valid is the registered HOLD state.

    state_t            state;
    state_t            state_next;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic              ovf;

    logic              accept;
    logic              close_run;
    logic              zero_run;
    logic [ACC_W:0]    sum_ext;
    logic [CNT_W-1:0]  count_inc;

    // A clear in IDLE/ACCUM drops any product offered in the same cycle.
    assign accept    = in_valid && in_ready && !clear;
    assign sum_ext   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    assign count_inc = count + CNT_W'(1);
    assign close_run = in_last || (count_inc == CNT_W'(MAX_TERMS));
    assign zero_run  = (state == ST_HOLD) ? out_ready : clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (clear) begin
                    state_next = ST_IDLE;
                end else if (accept) begin
                    state_next = close_run ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || zero_run) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc   <= sum_ext[ACC_W-1:0];
            count <= count_inc;
            ovf   <= ovf | sum_ext[ACC_W];
        end
    end

    always_comb begin
        in_ready     = (state != ST_HOLD);
        out_valid    = (state == ST_HOLD);
        out_sum      = '0;
        out_count    = '0;
        out_overflow = 1'b0;
        if (state == ST_HOLD) begin
            out_sum      = acc;
            out_count    = count;
            out_overflow = ovf;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed runs plus random runs,
// results checked against an expected queue filled when each run is driven.
module tb_product_accumulator;

    localparam int ACC_W     = 10;
    localparam int MAX_TERMS = 16;
    localparam int CNT_W     = 5;
    localparam int RES_W     = ACC_W + CNT_W + 1;

    logic             clk;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_product;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    logic [RES_W-1:0] exp_q[$];
    int               prod_buf[MAX_TERMS];
    int               checks = 0;
    int               errors = 0;

    product_accumulator #(
        .ACC_W(ACC_W),
        .MAX_TERMS(MAX_TERMS),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_product(in_product),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_count(out_count),
        .out_overflow(out_overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected result built from the unwrapped total: any carry out of
    // ACC_W means the true total reached 2**ACC_W.
    function automatic logic [RES_W-1:0] expect_run(input int n);
        int total;
        logic [ACC_W-1:0] s;
        logic [CNT_W-1:0] c;
        total = 0;
        for (int i = 0; i < n; i++) total += prod_buf[i];
        s = ACC_W'(total % (1 << ACC_W));
        c = CNT_W'(n);
        return {s, c, (total >= (1 << ACC_W))};
    endfunction

    // scoreboard
    always @(negedge clk) begin
        logic [RES_W-1:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_sum", 32'(out_sum), 32'(e[RES_W-1 -: ACC_W]));
                check("out_count", 32'(out_count), 32'(e[CNT_W:1]));
                check("out_overflow", 32'(out_overflow), 32'(e[0]));
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic accept_one(input int p, input logic last);
        int w;
        in_valid   = 1'b1;
        in_product = 8'(p);
        in_last    = last;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w == 50) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_terms(input int n, input logic with_last);
        exp_q.push_back(expect_run(n));
        for (int i = 0; i < n; i++) accept_one(prod_buf[i], with_last && (i == n - 1));
        check("valid_after_close", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w == 50) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_sum"}, 32'(out_sum), 32'd0);
        check({tag, "_out_count"}, 32'(out_count), 32'd0);
        check({tag, "_out_overflow"}, 32'(out_overflow), 32'd0);
    endtask

    initial begin
        int n;
        int hold_cycles;
        logic [RES_W-1:0] e;
        logic             with_last;

        rst        = 1'b1;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_product = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        do_reset();
        check_zero_outputs("reset");

        // single term
        prod_buf[0] = 225;
        run_terms(1, 1'b1);
        wait_drain();

        // wrap with overflow: 5 x 225 = 1125 -> 101
        for (int i = 0; i < 5; i++) prod_buf[i] = 225;
        run_terms(5, 1'b1);
        wait_drain();

        // auto-close at MAX_TERMS with in_last never set
        for (int i = 0; i < MAX_TERMS; i++) prod_buf[i] = 1;
        run_terms(MAX_TERMS, 1'b0);
        wait_drain();

        // zero products are still terms
        prod_buf[0] = 0;
        prod_buf[1] = 0;
        prod_buf[2] = 5;
        run_terms(3, 1'b1);
        wait_drain();

        // backpressure, with clear ignored while holding
        out_ready   = 1'b0;
        prod_buf[0] = 100;
        prod_buf[1] = 200;
        prod_buf[2] = 150;
        run_terms(3, 1'b1);
        e = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            in_product = 8'd99;
            in_last    = 1'b1;
            clear      = (i == 2);
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_sum", 32'(out_sum), 32'(e[RES_W-1 -: ACC_W]));
            check("bp_out_count", 32'(out_count), 32'(e[CNT_W:1]));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        prod_buf[0] = 9;
        prod_buf[1] = 11;
        run_terms(2, 1'b1);
        wait_drain();

        // clear mid-run drops the product offered with it
        accept_one(30, 1'b0);
        accept_one(40, 1'b0);
        clear      = 1'b1;
        in_valid   = 1'b1;
        in_product = 8'd50;
        in_last    = 1'b1;
        #1 check("clear_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_zero_outputs("after_clear");
        prod_buf[0] = 7;
        run_terms(1, 1'b1);
        wait_drain();

        // random runs with random backpressure
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, MAX_TERMS);
            with_last = (n < MAX_TERMS) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) prod_buf[i] = $urandom_range(0, 225);
            hold_cycles = $urandom_range(0, 3);
            out_ready = (hold_cycles == 0);
            run_terms(n, with_last);
            repeat (hold_cycles) @(posedge clk);
            #1 out_ready = 1'b1;
            wait_drain();
        end

        // reset while a result is pending discards it
        out_ready   = 1'b0;
        prod_buf[0] = 200;
        run_terms(1, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_zero_outputs("reset_in_hold");
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        out_ready   = 1'b1;
        prod_buf[0] = 3;
        run_terms(1, 1'b1);
        wait_drain();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
